// File: rtl/pe_pkg.sv
// Shared types for the PE row result drain path.
// Entry widths follow the default row geometry; keep them in step with pe_row_drain parameters.
package pe_pkg;

    localparam int D_W     = 8;
    localparam int D_W_ACC = 16;
    localparam int ROW_N   = 4;
    localparam int IDX_W   = (ROW_N > 1) ? $clog2(ROW_N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } drain_state_t;

    typedef struct packed {
        logic               last;
        logic [IDX_W-1:0]   idx;
        logic [D_W_ACC-1:0] data;
    } drain_entry_t;

endpackage

// File: rtl/drain_fifo.sv
// Purpose: show-ahead synchronous FIFO of drain_entry_t with occupancy count.
// Latency: a pushed entry is at the head the cycle after its write edge.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
module drain_fifo
    import pe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  drain_entry_t           i_dat,
    input  logic                   i_pop,
    output drain_entry_t           o_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    drain_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_pop;
    logic         w_do_push;

    // Extra pointer MSB separates the full and empty cases when the low bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dat     = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end

endmodule

// File: rtl/pe_row_drain.sv
// Purpose: buffer a PE row's N-word result burst, tag column/last, flag drops and short bursts (DRAIN_STATS_EN adds bursts_done).
// Latency: a captured word is on m_* the cycle after its capture edge.
// Backpressure: input cannot stall; words arriving while full with no pop are dropped and flagged.
module pe_row_drain
    import pe_pkg::*;
#(
    parameter int D_W_ACC = pe_pkg::D_W_ACC,
    parameter int N       = pe_pkg::ROW_N,
    parameter int DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [D_W_ACC-1:0]                in_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [D_W_ACC-1:0]                m_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_idx,
    output logic                              m_last,
    output logic [$clog2(DEPTH):0]            count,
    output logic                              overflow,
    output logic                              gap_err,
    input  logic                              clr
`ifdef DRAIN_STATS_EN
    ,
    output logic [15:0]                       bursts_done
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    drain_state_t  r_state;
    logic [IW-1:0] r_k;
    logic          r_overflow;
    logic          r_gap_err;

    drain_entry_t  w_entry;
    drain_entry_t  w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_gap;
    logic          w_last;
    logic [IW-1:0] w_idx;

    // The row's last PE shifts out its own result first, so column index counts down.
    assign w_last  = (r_k == IW'(N - 1));
    assign w_idx   = IW'(N - 1) - r_k;
    assign w_entry = '{last: w_last, idx: w_idx, data: in_data};

    assign w_pop   = !w_empty && m_ready;
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;
    assign w_gap   = (r_state == BURST) && !in_valid;

    drain_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (w_entry),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign m_valid  = !w_empty;
    assign m_data   = w_head.data;
    assign m_idx    = w_head.idx;
    assign m_last   = w_head.last;
    assign overflow = r_overflow;
    assign gap_err  = r_gap_err;

    // k advances on every arriving word, dropped or not, so later tags stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_overflow <= 1'b0;
            r_gap_err  <= 1'b0;
        end else begin
            if (in_valid) begin
                if (w_last) begin
                    r_k     <= '0;
                    r_state <= IDLE;
                end else begin
                    r_k     <= r_k + IW'(1);
                    r_state <= BURST;
                end
            end else if (r_state == BURST) begin
                r_k     <= '0;
                r_state <= IDLE;
            end
            r_overflow <= (r_overflow && !clr) || w_drop;
            r_gap_err  <= (r_gap_err && !clr) || w_gap;
        end
    end

`ifdef DRAIN_STATS_EN
    logic [15:0] r_bursts_done;
    logic        w_burst_end;

    assign w_burst_end = in_valid && w_last;
    assign bursts_done = r_bursts_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bursts_done <= '0;
        end else if (clr) begin
            r_bursts_done <= w_burst_end ? 16'd1 : 16'd0;
        end else if (w_burst_end) begin
            r_bursts_done <= r_bursts_done + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_row_drain.sv
// Directed bench for pe_row_drain at N=4, DEPTH=8 with hand-computed expectations.
module tb_pe_row_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        m_ready = 1'b0;
    logic        clr = 1'b0;
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_idx;
    logic        m_last;
    logic [3:0]  count;
    logic        overflow;
    logic        gap_err;
`ifdef DRAIN_STATS_EN
    logic [15:0] bursts_done;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pe_row_drain #(
        .D_W_ACC (16),
        .N       (4),
        .DEPTH   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_idx       (m_idx),
        .m_last      (m_last),
        .count       (count),
        .overflow    (overflow),
        .gap_err     (gap_err),
        .clr         (clr)
`ifdef DRAIN_STATS_EN
        ,
        .bursts_done (bursts_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        tick();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Checks the head word, then lets it pop (m_ready must be 1).
    task automatic drain_one(input string tag, input logic [15:0] d, input logic [1:0] idx,
                             input logic last);
        chk({tag, "_vld"},  32'(m_valid), 32'd1);
        chk({tag, "_dat"},  32'(m_data),  32'(d));
        chk({tag, "_idx"},  32'(m_idx),   32'(idx));
        chk({tag, "_last"}, 32'(m_last),  32'(last));
        tick();
    endtask

    initial begin
        logic [15:0] gd [6];
        logic [1:0]  gi [6];
        logic [15:0] fd [8];
        logic [1:0]  fi [8];
        logic        fl [8];
        gd = '{16'd100, 16'd101, 16'd102, 16'd103, 16'd104, 16'd105};
        gi = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        fd = '{16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 16'd106, 16'd107, 16'd200};
        fi = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        fl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held with random input activity.
        for (int i = 0; i < 3; i++) begin
            feed(1'($urandom_range(1)), 16'($urandom));
            chk("rst_vld", 32'(m_valid), 32'd0);
            chk("rst_cnt", 32'(count), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            chk("rst_gap", 32'(gap_err), 32'd0);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_vld", 32'(m_valid), 32'd0);
        chk("post_rst_dat", 32'(m_data), 32'd0);
        chk("post_rst_idx", 32'(m_idx), 32'd0);
        chk("post_rst_last", 32'(m_last), 32'd0);

        // Single burst streamed straight through.
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            feed(1'b1, 16'(100 + i));
            chk("b1_vld", 32'(m_valid), 32'd1);
            chk("b1_dat", 32'(m_data), 32'(100 + i));
            chk("b1_idx", 32'(m_idx), 32'(3 - i));
            chk("b1_last", 32'(m_last), 32'(i == 3));
            chk("b1_cnt", 32'(count), 32'd1);
        end
        feed(1'b0, '0);
        chk("b1_empty", 32'(m_valid), 32'd0);
        chk("b1_gap", 32'(gap_err), 32'd0);

        // Fill, overflow, then drain exactly the first two bursts.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(1'b1, 16'(100 + i));
        chk("fill_cnt", 32'(count), 32'd8);
        chk("fill_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) feed(1'b1, 16'(108 + i));
        feed(1'b0, '0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd8);
        chk("ovf_hold", 32'(m_data), 32'd100);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            drain_one("ovf_drain", 16'(100 + i), 2'(3 - (i % 4)), (i == 3) || (i == 7));
        chk("ovf_empty", 32'(m_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        pulse_clr();
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Short burst followed by a full one.
        m_ready = 1'b0;
        feed(1'b1, 16'd100);
        feed(1'b1, 16'd101);
        feed(1'b0, '0);
        chk("gap_flag", 32'(gap_err), 32'd1);
        for (int i = 0; i < 4; i++) feed(1'b1, 16'(102 + i));
        feed(1'b0, '0);
        chk("gap_cnt", 32'(count), 32'd6);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) drain_one("gap_drain", gd[i], gi[i], i == 5);
        chk("gap_sticky", 32'(gap_err), 32'd1);
        pulse_clr();
        chk("gap_clr", 32'(gap_err), 32'd0);

        // Set condition coinciding with clr keeps the flag.
        feed(1'b1, 16'd300);
        chk("sw_idx", 32'(m_idx), 32'd3);
        clr = 1'b1;
        feed(1'b0, '0);
        clr = 1'b0;
        chk("sw_gap", 32'(gap_err), 32'd1);
        pulse_clr();
        chk("sw_clr", 32'(gap_err), 32'd0);

        // Push and pop together while full.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(1'b1, 16'(100 + i));
        chk("fp_full", 32'(count), 32'd8);
        m_ready = 1'b1;
        feed(1'b1, 16'd200);
        chk("fp_cnt", 32'(count), 32'd8);
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_head", 32'(m_data), 32'd101);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) drain_one("fp_drain", fd[i], fi[i], fl[i]);
        chk("fp_empty", 32'(m_valid), 32'd0);
        chk("fp_gap", 32'(gap_err), 32'd1);
        pulse_clr();

        // Reset in the middle of a burst.
        m_ready = 1'b0;
        feed(1'b1, 16'd100);
        feed(1'b1, 16'd101);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_cnt", 32'(count), 32'd0);
        chk("mr_vld", 32'(m_valid), 32'd0);
        for (int i = 0; i < 4; i++) feed(1'b1, 16'(102 + i));
`ifdef DRAIN_STATS_EN
        chk("mr_bursts", 32'(bursts_done), 32'd1);
`endif
        feed(1'b0, '0);
        chk("mr_cnt4", 32'(count), 32'd4);
        chk("mr_gap", 32'(gap_err), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) drain_one("mr_drain", 16'(102 + i), 2'(3 - i), i == 3);
        chk("mr_empty", 32'(m_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
